// File: rtl/my_pulse_stretcher.sv
// my_pulse_stretcher: stretches each input event into a WIDTH-cycle pulse with GAP low cycles between pulses.
// Optional event queue enabled by defining PULSE_QUEUE_EN.
`default_nettype none

module my_pulse_stretcher #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned GAP    = 1,
  parameter int unsigned PEND_W = 2
) (
  input  logic              clk,
  input  logic              synch_reset,
  input  logic              signal_input,
  output logic              signal_output,
  output logic              busy,
  output logic [PEND_W-1:0] pending_count,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] HIGH_LAST = 8'(WIDTH - 1);
  localparam logic [7:0] GAP_LAST  = 8'((GAP == 0) ? 0 : GAP - 1);
  localparam bit         NO_GAP    = (GAP == 0);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       decision;
  logic       lost;
  logic       have_pend;
  logic       pend_nz_nx;

`ifdef PULSE_QUEUE_EN
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  logic [PEND_W-1:0] pend, pend_nx;

  assign have_pend     = (pend != '0);
  assign pend_nz_nx    = (pend_nx != '0);
  assign pending_count = pend;
`else
  assign have_pend     = 1'b0;
  assign pend_nz_nx    = 1'b0;
  assign pending_count = '0;
`endif

  // Decision cycle: last GAP cycle, or last HIGH cycle when there is no gap.
  assign decision = ((state == S_HIGH) && (cnt == HIGH_LAST) && NO_GAP) ||
                    ((state == S_GAP)  && (cnt == GAP_LAST));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lost     = 1'b0;
`ifdef PULSE_QUEUE_EN
    pend_nx  = pend;
`endif
    case (state)
      S_IDLE: begin
        if (signal_input) begin
          state_nx = S_HIGH;
          cnt_nx   = 8'd0;
        end
      end
      S_HIGH, S_GAP: begin
        if (decision) begin
          if (have_pend || signal_input) begin
            state_nx = S_HIGH;
            cnt_nx   = 8'd0;
`ifdef PULSE_QUEUE_EN
            // A queued restart with a simultaneous event leaves the count unchanged.
            if (have_pend && !signal_input) pend_nx = pend - 1'b1;
`endif
          end else begin
            state_nx = S_IDLE;
            cnt_nx   = 8'd0;
          end
        end else begin
          if ((state == S_HIGH) && (cnt == HIGH_LAST)) begin
            state_nx = S_GAP;
            cnt_nx   = 8'd0;
          end else begin
            cnt_nx = cnt + 8'd1;
          end
          if (signal_input) begin
`ifdef PULSE_QUEUE_EN
            if (pend == PEND_MAX) lost = 1'b1;
            else                  pend_nx = pend + 1'b1;
`else
            lost = 1'b1;
`endif
          end
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (synch_reset) begin
      state         <= S_IDLE;
      cnt           <= 8'd0;
      signal_output <= 1'b0;
      busy          <= 1'b0;
      overflow      <= 1'b0;
`ifdef PULSE_QUEUE_EN
      pend          <= '0;
`endif
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      signal_output <= (state_nx == S_HIGH);
      busy          <= (state_nx != S_IDLE) || pend_nz_nx;
      overflow      <= lost;
`ifdef PULSE_QUEUE_EN
      pend          <= pend_nx;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_my_pulse_stretcher.sv
// Randomized self-checking bench: two stretcher configurations against a timeline-based reference model.
`default_nettype none

module tb_my_pulse_stretcher;

  localparam int W0 = 4, G0 = 2, P0 = 2;
  localparam int W1 = 3, G1 = 0, P1 = 3;
  localparam int N_CYCLES = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, din;
  logic out0, busy0, ov0;
  logic out1, busy1, ov1;
  logic [P0-1:0] pc0;
  logic [P1-1:0] pc1;

  my_pulse_stretcher #(.WIDTH(W0), .GAP(G0), .PEND_W(P0)) dut0 (
    .clk(clk), .synch_reset(rst), .signal_input(din),
    .signal_output(out0), .busy(busy0), .pending_count(pc0), .overflow(ov0)
  );

  my_pulse_stretcher #(.WIDTH(W1), .GAP(G1), .PEND_W(P1)) dut1 (
    .clk(clk), .synch_reset(rst), .signal_input(din),
    .signal_output(out1), .busy(busy1), .pending_count(pc1), .overflow(ov1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
  endtask

  // Model: each pulse is a timeline anchored at its start cycle s; HIGH is
  // [s, s+W-1], gap follows, decision cycle is s+W+G-1.
  int  wid[2]  = '{W0, W1};
  int  gp[2]   = '{G0, G1};
  int  pmax[2] = '{(1 << P0) - 1, (1 << P1) - 1};
  int  s[2], pend[2];
  int  e_out[2], e_busy[2], e_pend[2], e_ov[2];
  bit  qen;

  task automatic model_step(input int k, input int t, input bit r, input bit ev);
    int d;
    int lost;
    lost = 0;
    if (r) begin
      s[k]    = -1000;
      pend[k] = 0;
    end else begin
      d = s[k] + wid[k] + gp[k] - 1;
      if (t > d) begin
        if (ev) s[k] = t + 1;
      end else if (t == d) begin
        if (pend[k] > 0) begin
          s[k] = t + 1;
          if (!ev) pend[k] = pend[k] - 1;
        end else if (ev) begin
          s[k] = t + 1;
        end
      end else if (ev) begin
        if (qen && pend[k] < pmax[k]) pend[k] = pend[k] + 1;
        else lost = 1;
      end
    end
    e_out[k]  = ((t + 1 >= s[k]) && (t + 1 <= s[k] + wid[k] - 1)) ? 1 : 0;
    e_busy[k] = ((t + 1 <= s[k] + wid[k] + gp[k] - 1) || pend[k] > 0) ? 1 : 0;
    e_pend[k] = pend[k];
    e_ov[k]   = lost;
  endtask

  initial begin
    int dens;
    bit r, ev;
`ifdef PULSE_QUEUE_EN
    qen = 1'b1;
`else
    qen = 1'b0;
`endif
    for (int k = 0; k < 2; k++) begin
      s[k] = -1000; pend[k] = 0;
      e_out[k] = 0; e_busy[k] = 0; e_pend[k] = 0; e_ov[k] = 0;
    end
    rst = 1'b1;
    din = 1'b0;

    for (int i = 0; i < N_CYCLES; i++) begin
      @(negedge clk);
      check("out0",  int'(out0),  e_out[0]);
      check("busy0", int'(busy0), e_busy[0]);
      check("pend0", int'(pc0),   e_pend[0]);
      check("ovf0",  int'(ov0),   e_ov[0]);
      check("out1",  int'(out1),  e_out[1]);
      check("busy1", int'(busy1), e_busy[1]);
      check("pend1", int'(pc1),   e_pend[1]);
      check("ovf1",  int'(ov1),   e_ov[1]);

      case ((i / 200) % 4)
        0:       dens = 5;
        1:       dens = 30;
        2:       dens = 70;
        default: dens = 100;
      endcase
      r  = (i < 3) || ($urandom_range(99) == 0);
      ev = ($urandom_range(99) < dens);
      rst = r;
      din = ev;
      model_step(0, cyc, r, ev);
      model_step(1, cyc, r, ev);
      cyc++;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/my_pulse_stretcher.md
MY_PULSE_STRETCHER -- requirements
Module: my_pulse_stretcher

Interface
REQ-001 Parameter WIDTH, default 4: number of cycles signal_output is held high per event; legal range 1..255.
REQ-002 Parameter GAP, default 1: minimum number of low cycles between consecutive output pulses; legal range 0..255.
REQ-003 Parameter PEND_W, default 2: width of the pending-event counter; legal range 1..8.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 synch_reset  input  1  reset, synchronous, active-high.
REQ-006 signal_input  input  1  event strobe; each cycle sampled high is exactly one event.
REQ-007 signal_output  output  1  registered stretched pulse.
REQ-008 busy  output  1  high while the FSM is not in IDLE or pending_count is nonzero.
REQ-009 pending_count  output  PEND_W  number of queued events not yet emitted.
REQ-010 overflow  output  1  registered one-cycle pulse for each event that is lost.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, HIGH and GAP; signal_output SHALL be high only in HIGH.
REQ-012 IDLE: an event in cycle t SHALL produce HIGH in cycles t+1..t+WIDTH; no other event source exists in IDLE.
REQ-013 HIGH SHALL last exactly WIDTH cycles; the FSM then enters GAP for exactly GAP cycles, or skips GAP when GAP=0.
REQ-014 The decision cycle is the last GAP cycle, or the last HIGH cycle when GAP=0.
REQ-015 In the decision cycle, if pending_count>0 or an event is sampled, HIGH SHALL restart in the next cycle (back-to-back); otherwise the FSM SHALL go to IDLE.
REQ-016 When HIGH restarts from the queue, pending_count SHALL decrement by one; an event sampled in the same cycle SHALL be queued, so the net count is unchanged.
REQ-017 When the queue is empty in the decision cycle, an event sampled in that cycle SHALL start the restart directly and SHALL NOT be counted.
REQ-018 An event sampled in HIGH or GAP outside the decision cycle SHALL be handled as defined under Configuration.
REQ-019 pending_count SHALL saturate at 2^PEND_W-1; it SHALL never wrap.
REQ-020 overflow SHALL be high in cycle t+1 for each event lost in cycle t.
REQ-021 The outputs busy, signal_output and overflow SHALL be driven from registers, with no combinational path from signal_input.

Reset
REQ-022 While synch_reset is high at a clock edge: state IDLE, signal_output 0, pending_count 0, overflow 0, busy 0; signal_input ignored.
REQ-023 Reset asserted mid-HIGH SHALL force signal_output low in the following cycle and discard all queued events without raising overflow.

Configuration
REQ-024 Macro PULSE_QUEUE_EN defined: events sampled in HIGH/GAP outside the decision cycle SHALL increment pending_count; an event arriving at saturation is lost and raises overflow.
REQ-025 Macro PULSE_QUEUE_EN undefined: such events SHALL be dropped with overflow; pending_count SHALL be tied to 0 and no counter logic is built.

Verification (WIDTH=4, GAP=2, PEND_W=2 unless stated)
REQ-026 Single event at cycle 10 -> signal_output high 11-14, low 15-16, busy high 11-16, overflow never.
REQ-027 PULSE_QUEUE_EN, events at 10, 12 and 13 -> signal_output high 11-14, 17-20 and 23-26; pending_count 2 at cycle 14, 1 at 17, 0 at 23.
REQ-028 PULSE_QUEUE_EN, events at 10-14 -> pending_count saturates at 3 by cycle 14; overflow high at cycle 15 only.
REQ-029 Queue disabled, events at 10 and 12 -> one output pulse 11-14; overflow high at cycle 13.
REQ-030 GAP=0, events at 10 and 14 -> signal_output continuously high 11-18, then low; busy falls at 19.
REQ-031 PULSE_QUEUE_EN, events at 10 and 12, synch_reset high at cycle 12 -> signal_output low from 13, pending_count 0, overflow never, no further pulse.
